// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the two-port SPI engine arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GUARD  = 2'd3
  } arb_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int GYRO_PORT  = 0;
  localparam int ACCEL_PORT = 1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_arb_guard_timer.sv
// rtl/spi_arb_guard_timer.sv - loadable down-counter shared by the guard gap and the watchdog
module spi_arb_guard_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Saturates at zero so a caller may keep dec_i high while it waits on zero_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin owner of one byte-level SPI engine for gyro (0) and accel (1)
// Optional watchdog that revokes an idle grant: define SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              begin0,
  input  logic              begin1,
  input  logic [DATA_W-1:0] send_data0,
  input  logic [DATA_W-1:0] send_data1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_begin,
  output logic [DATA_W-1:0] spi_send_data,
  input  logic              spi_end,
  input  logic [DATA_W-1:0] spi_rx_data,
  output logic [1:0]        ss_n,
  output logic              busy
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int TMR_W   = cnt_width(TMR_MAX);
  // The IDLE arbitration cycle is itself one high ss_n clock, so GUARD lasts one less.
  localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'((GUARD_CYCLES > 1) ? GUARD_CYCLES - 2 : 0);
`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

  arb_state_e        state_q;
  logic              grant0_q;
  logic              grant1_q;
  logic              last_grant_q;
  logic              spi_begin_q;
  logic              busy_q;
  logic [1:0]        ss_n_q;
  logic [DATA_W-1:0] spi_send_data_q;

  logic              in_grant;
  logic              own_begin;
  logic              own_req;
  logic [DATA_W-1:0] own_data;
  logic              accept;
  logic              release_ok;
  logic              timeout_hit;
  logic              tmr_load;
  logic              tmr_dec;
  logic              tmr_zero;
  logic [TMR_W-1:0]  tmr_val;

  always_comb begin
    in_grant    = grant0_q | grant1_q;
    own_begin   = (grant0_q & begin0) | (grant1_q & begin1);
    own_req     = (grant0_q & req0) | (grant1_q & req1);
    own_data    = grant1_q ? send_data1 : send_data0;
    accept      = own_begin & ~busy_q;
    release_ok  = in_grant & ~own_req & ~busy_q & ~accept;
    timeout_hit = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_val     = GUARD_LOAD;
`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog restarts on grant entry and on any owner begin or engine completion.
    timeout_hit = in_grant & tmr_zero & ~own_begin & ~spi_end & ~release_ok;
    if (state_q == IDLE) begin
      tmr_load = req0 | req1;
      tmr_val  = TIMEOUT_LOAD;
    end else if (in_grant) begin
      if (own_begin | spi_end) begin
        tmr_load = 1'b1;
        tmr_val  = TIMEOUT_LOAD;
      end else begin
        tmr_dec = 1'b1;
      end
    end
`endif
    if (release_ok | timeout_hit) begin
      tmr_load = 1'b1;
      tmr_val  = GUARD_LOAD;
    end
    if (state_q == GUARD) begin
      tmr_dec = 1'b1;
    end
  end

  spi_arb_guard_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      grant0_q        <= 1'b0;
      grant1_q        <= 1'b0;
      last_grant_q    <= 1'(ACCEL_PORT);
      spi_begin_q     <= 1'b0;
      busy_q          <= 1'b0;
      ss_n_q          <= 2'b11;
      spi_send_data_q <= '0;
    end else begin
      spi_begin_q <= 1'b0;
      if (in_grant && spi_end) begin
        busy_q <= 1'b0;
      end
      if (accept) begin
        spi_begin_q     <= 1'b1;
        spi_send_data_q <= own_data;
        busy_q          <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            // On a tie the port that did not own the engine last time wins.
            if (req0 && (!req1 || last_grant_q)) begin
              state_q           <= GRANT0;
              grant0_q          <= 1'b1;
              ss_n_q[GYRO_PORT] <= 1'b0;
            end else begin
              state_q            <= GRANT1;
              grant1_q           <= 1'b1;
              ss_n_q[ACCEL_PORT] <= 1'b0;
            end
          end
        end
        GRANT0, GRANT1: begin
          if (release_ok || timeout_hit) begin
            grant0_q     <= 1'b0;
            grant1_q     <= 1'b0;
            ss_n_q       <= 2'b11;
            busy_q       <= 1'b0;
            last_grant_q <= grant1_q;
            state_q      <= (GUARD_CYCLES > 1) ? GUARD : IDLE;
          end
        end
        GUARD: begin
          if (tmr_zero) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  assign grant0        = grant0_q;
  assign grant1        = grant1_q;
  assign ss_n          = ss_n_q;
  assign spi_begin     = spi_begin_q;
  assign spi_send_data = spi_send_data_q;
  assign busy          = busy_q;
  assign done0         = spi_end & grant0_q;
  assign done1         = spi_end & grant1_q;
  assign rx_data       = spi_rx_data;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - directed bench with a per-cycle behavioural model of spi_bus_arbiter
module tb_spi_bus_arbiter;

  localparam int DW      = 8;
  localparam int GUARD_N = 16;
  localparam int TOUT_N  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, begin0 = 1'b0, begin1 = 1'b0;
  logic [DW-1:0] sd0 = '0, sd1 = '0, spi_rx = '0;
  logic          spi_end = 1'b0;
  logic          grant0, grant1, done0, done1, spi_begin, busy;
  logic [DW-1:0] rx_data, spi_send_data;
  logic [1:0]    ss_n;
`ifdef SPI_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  spi_bus_arbiter #(
    .DATA_W(DW), .GUARD_CYCLES(GUARD_N), .TIMEOUT_CYCLES(TOUT_N)
  ) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .begin0(begin0), .begin1(begin1),
    .send_data0(sd0), .send_data1(sd1), .grant0(grant0), .grant1(grant1),
    .done0(done0), .done1(done1), .rx_data(rx_data), .spi_begin(spi_begin),
    .spi_send_data(spi_send_data), .spi_end(spi_end), .spi_rx_data(spi_rx),
    .ss_n(ss_n), .busy(busy)
`ifdef SPI_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: who owns the engine, how many edges the guard still holds, byte in flight.
  int          owner = -1;
  int          last_own = 1;
  int          wait_left = 0;
  int          idle_cnt = 0;
  bit          mbusy = 0, mbeg = 0, merr = 0, mvalid = 0;
  logic [DW-1:0] mdata = '0;
  bit          m_b, m_r, m_acc, m_rel, m_to;

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; last_own = 1; wait_left = 0; idle_cnt = 0;
      mbusy = 0; mbeg = 0; mdata = '0; merr = 0; mvalid = 1;
    end else begin
      mbeg = 0;
      if (owner >= 0) begin
        m_b   = (owner == 0) ? begin0 : begin1;
        m_r   = (owner == 0) ? req0 : req1;
        m_acc = m_b && !mbusy;
        m_rel = !m_r && !mbusy && !m_acc;
        m_to  = 0;
`ifdef SPI_ARB_TIMEOUT_EN
        if (m_b || spi_end) idle_cnt = 0;
        else idle_cnt++;
        m_to = !m_rel && (idle_cnt >= TOUT_N);
`endif
        if (spi_end) mbusy = 0;
        if (m_acc) begin
          mbeg = 1;
          mdata = (owner == 0) ? sd0 : sd1;
          mbusy = 1;
        end
        if (m_rel || m_to) begin
          last_own = owner; owner = -1; mbusy = 0;
          wait_left = GUARD_N - 1;
          if (m_to) merr = 1;
        end
      end else if (wait_left > 0) begin
        wait_left--;
      end else if (req0 || req1) begin
        owner = (req0 && req1) ? 1 - last_own : (req0 ? 0 : 1);
        idle_cnt = 0;
      end
    end
  end

  int            d0_cnt = 0;
  logic [DW-1:0] last_rx0 = '0;
  logic [1:0]    ess;
  logic [23:0]   exp_v, act_v;

  always @(negedge clk) begin
    if (mvalid) begin
      ess = 2'b11;
      if (owner == 0) ess[0] = 1'b0;
      else if (owner == 1) ess[1] = 1'b0;
      exp_v = {owner == 0, owner == 1, ess, mbeg, mdata, mbusy,
               spi_end && owner == 0, spi_end && owner == 1, spi_rx};
      act_v = {grant0, grant1, ss_n, spi_begin, spi_send_data, busy, done0, done1, rx_data};
      chk("cycle_outputs", act_v, exp_v);
      chk("ss_n_not_both_low", ss_n == 2'b00, 0);
      chk("grants_exclusive", grant0 & grant1, 0);
`ifdef SPI_ARB_TIMEOUT_EN
      chk("cycle_timeout_err", timeout_err, merr);
`endif
      if (done0) begin
        d0_cnt++;
        last_rx0 = rx_data;
      end
    end
  end

  task automatic wait_grant(input int port);
    int n = 0;
    while (!((port == 0) ? grant0 : grant1) && n < 200) begin
      step();
      n++;
    end
    chk("wait_grant", (port == 0) ? grant0 : grant1, 1);
  endtask

  task automatic wait_any(output int who);
    int n = 0;
    while (!(grant0 | grant1) && n < 200) begin
      step();
      n++;
    end
    chk("wait_any_grant", grant0 | grant1, 1);
    who = grant1 ? 1 : 0;
  endtask

  task automatic end_byte(input logic [DW-1:0] rx);
    spi_end = 1'b1; spi_rx = rx;
    step();
    spi_end = 1'b0;
  endtask

  initial begin
    int hi, d0_start, who;
    int order[6];

    step(2);
    rst = 1'b0;
    chk("rst_grant0", grant0, 0);
    chk("rst_grant1", grant1, 0);
    chk("rst_ss_n", ss_n, 2'b11);
    chk("rst_spi_begin", spi_begin, 0);
    chk("rst_send_data", spi_send_data, 0);
    chk("rst_busy", busy, 0);

    // Gyro alone, two bytes, then the guard gap before it may own the engine again.
    req0 = 1'b1;
    chk("t1_no_grant_yet", grant0, 0);
    step();
    chk("t1_grant0", grant0, 1);
    chk("t1_ss_n", ss_n, 2'b10);
    d0_start = d0_cnt;
    sd0 = 8'hE8; begin0 = 1'b1;
    step();
    begin0 = 1'b0;
    chk("t1_spi_begin", spi_begin, 1);
    chk("t1_send_e8", spi_send_data, 8'hE8);
    step(3);
    end_byte(8'h33);
    sd0 = 8'h00; begin0 = 1'b1;
    step();
    begin0 = 1'b0;
    chk("t1_send_00", spi_send_data, 8'h00);
    step(4);
    end_byte(8'h5A);
    chk("t1_done_count", d0_cnt - d0_start, 2);
    chk("t1_rx_5a", last_rx0, 8'h5A);
    req0 = 1'b0;
    step();
    chk("t1_released", grant0, 0);
    req0 = 1'b1;
    hi = 0;
    while (!grant0 && hi < 100) begin
      hi++;
      step();
    end
    chk("t1_guard_len", hi, 16);
    req0 = 1'b0;
    step(20);

    // Tie straight after reset goes to the gyro, then the accel after the guard.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("t2_tie_grant0", grant0, 1);
    chk("t2_tie_grant1", grant1, 0);
    req0 = 1'b0;
    step();
    wait_grant(1);
    chk("t2_ss_n_accel", ss_n, 2'b01);
    req1 = 1'b0;
    step(20);

    // Both requesting: ownership alternates.
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_any(who);
      order[k] = who;
      if (who == 0) begin0 = 1'b1; else begin1 = 1'b1;
      step();
      begin0 = 1'b0; begin1 = 1'b0;
      step(2);
      end_byte(8'h10 + 8'(k));
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      step();
      req0 = 1'b1; req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 6; k++) chk($sformatf("t3_order_%0d", k), order[k], k % 2);
    step(20);

    // Request dropped mid-byte: grant held until the byte ends.
    req0 = 1'b1;
    wait_grant(0);
    sd0 = 8'h3C; begin0 = 1'b1;
    step();
    begin0 = 1'b0; req0 = 1'b0;
    step(19);
    chk("t4_held", grant0, 1);
    spi_end = 1'b1; spi_rx = 8'hC3;
    #1;
    chk("t4_done0", done0, 1);
    chk("t4_rx", rx_data, 8'hC3);
    step();
    spi_end = 1'b0;
    chk("t4_release_cycle", grant0, 1);
    step();
    chk("t4_released", grant0, 0);
    step(20);

    // Begin while busy and begin from the other port are both ignored.
    req0 = 1'b1;
    wait_grant(0);
    sd0 = 8'h22; begin0 = 1'b1;
    step();
    chk("t5_first_begin", spi_send_data, 8'h22);
    sd0 = 8'h77;
    step();
    begin0 = 1'b0;
    chk("t5_busy_begin", spi_begin, 0);
    chk("t5_busy_data", spi_send_data, 8'h22);
    end_byte(8'h01);
    sd1 = 8'hA6; begin1 = 1'b1;
    step();
    begin1 = 1'b0;
    chk("t5_foreign_begin", spi_begin, 0);
    chk("t5_foreign_data", spi_send_data, 8'h22);
    req0 = 1'b0;
    step(20);

    // Reset mid-byte, then a late completion from the engine.
    req0 = 1'b1;
    wait_grant(0);
    sd0 = 8'h99; begin0 = 1'b1;
    step();
    begin0 = 1'b0;
    step(2);
    rst = 1'b1; req0 = 1'b0;
    step();
    rst = 1'b0;
    chk("t6_grant0", grant0, 0);
    chk("t6_ss_n", ss_n, 2'b11);
    chk("t6_busy", busy, 0);
    chk("t6_send_data", spi_send_data, 0);
    spi_end = 1'b1; spi_rx = 8'hEE;
    #1;
    chk("t6_no_done", done0, 0);
    step();
    spi_end = 1'b0;
    chk("t6_busy_after_end", busy, 0);
    step(4);

`ifdef SPI_ARB_TIMEOUT_EN
    req0 = 1'b1;
    wait_grant(0);
    chk("t6_err_clear", timeout_err, 0);
    step(TOUT_N - 1);
    chk("t6_grant_before_timeout", grant0, 1);
    step();
    chk("t6_timeout_revoked", grant0, 0);
    chk("t6_timeout_err", timeout_err, 1);
    req0 = 1'b0;
    step(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
